// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: MDU_* operation
// encodings, FSM state type and small op-classification helpers.
// Optional feature macro: MDU_MADD_EN (enables madd/maddu/msub/msubu).
package md_unit_pkg;

    localparam int MDU_OP_W = 5;

    localparam logic [MDU_OP_W-1:0] MDU_NONE  = 5'd0;
    localparam logic [MDU_OP_W-1:0] MDU_MULT  = 5'd1;
    localparam logic [MDU_OP_W-1:0] MDU_MULTU = 5'd2;
    localparam logic [MDU_OP_W-1:0] MDU_DIV   = 5'd3;
    localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 5'd4;
    localparam logic [MDU_OP_W-1:0] MDU_MFHI  = 5'd5;
    localparam logic [MDU_OP_W-1:0] MDU_MFLO  = 5'd6;
    localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 5'd7;
    localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 5'd8;
    localparam logic [MDU_OP_W-1:0] MDU_MADD  = 5'd9;
    localparam logic [MDU_OP_W-1:0] MDU_MADDU = 5'd10;
    localparam logic [MDU_OP_W-1:0] MDU_MSUB  = 5'd11;
    localparam logic [MDU_OP_W-1:0] MDU_MSUBU = 5'd12;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // True for every op that runs with the multiply latency.
    function automatic logic is_mul_op(input logic [MDU_OP_W-1:0] op);
        logic r;
        r = (op == MDU_MULT) || (op == MDU_MULTU);
`ifdef MDU_MADD_EN
        r = r || (op == MDU_MADD) || (op == MDU_MADDU) ||
                 (op == MDU_MSUB) || (op == MDU_MSUBU);
`endif
        return r;
    endfunction

    // True for ops that run with the divide latency.
    function automatic logic is_div_op(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // Ops that launch a multi-cycle run when start is asserted.
    function automatic logic is_run_op(input logic [MDU_OP_W-1:0] op);
        return is_mul_op(op) || is_div_op(op);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit result generator for the multiply/divide unit.
// Produces the {HI,LO} value an op will commit, given the operands and the
// current HI/LO. Divide by zero and unknown ops return HI/LO unchanged.
// Optional feature macro: MDU_MADD_EN (multiply-accumulate/subtract path).
module md_calc
    import md_unit_pkg::*;
(
    input  logic [MDU_OP_W-1:0] op,
    input  logic [31:0]         rs,
    input  logic [31:0]         rt,
    input  logic [31:0]         hi,
    input  logic [31:0]         lo,
    output logic [31:0]         res_hi,
    output logic [31:0]         res_lo
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] rs_abs;
    logic [31:0] rt_abs;
    logic [31:0] rt_safe;
    logic [31:0] rt_abs_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_signed;
    logic [31:0] r_signed;
    logic [31:0] q_unsigned;
    logic [31:0] r_unsigned;

    // Products and quotients; the divisor is forced nonzero so the divider
    // never sees zero, the zero case is handled in the result select below.
    always_comb begin
        // Sign-extended 64x64 keeps the low 64 bits equal to the signed product.
        prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
        prod_u = {32'd0, rs} * {32'd0, rt};

        rt_safe     = (rt == 32'd0) ? 32'd1 : rt;
        rs_abs      = rs[31] ? (32'd0 - rs) : rs;
        rt_abs      = rt[31] ? (32'd0 - rt) : rt;
        rt_abs_safe = (rt_abs == 32'd0) ? 32'd1 : rt_abs;

        // Magnitude division: 0x80000000 / -1 yields |q| = 0x80000000 which
        // negates to itself, giving the architectural LO=0x80000000, HI=0.
        q_mag    = rs_abs / rt_abs_safe;
        r_mag    = rs_abs % rt_abs_safe;
        q_signed = (rs[31] ^ rt[31]) ? (32'd0 - q_mag) : q_mag;
        r_signed = rs[31] ? (32'd0 - r_mag) : r_mag;

        q_unsigned = rs / rt_safe;
        r_unsigned = rs % rt_safe;
    end

    // Result select per operation.
    always_comb begin
        res_hi = hi;
        res_lo = lo;
        case (op)
            MDU_MULT:  {res_hi, res_lo} = prod_s;
            MDU_MULTU: {res_hi, res_lo} = prod_u;
            MDU_DIV: begin
                if (rt != 32'd0) begin
                    res_hi = r_signed;
                    res_lo = q_signed;
                end
            end
            MDU_DIVU: begin
                if (rt != 32'd0) begin
                    res_hi = r_unsigned;
                    res_lo = q_unsigned;
                end
            end
`ifdef MDU_MADD_EN
            MDU_MADD:  {res_hi, res_lo} = {hi, lo} + prod_s;
            MDU_MADDU: {res_hi, res_lo} = {hi, lo} + prod_u;
            MDU_MSUB:  {res_hi, res_lo} = {hi, lo} - prod_s;
            MDU_MSUBU: {res_hi, res_lo} = {hi, lo} - prod_u;
`endif
            default: begin
                res_hi = hi;
                res_lo = lo;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit. Holds architectural HI/LO, runs
// mult/multu/div/divu with a fixed latency and reports busy to the hazard
// unit. The result is computed at the start edge into pending registers and
// committed to HI/LO at the last busy cycle.
// Optional feature macro: MDU_MADD_EN (madd/maddu/msub/msubu, MULT latency).
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MDU_OP_W-1:0] mdu_op,
    input  logic [31:0]         rs_data,
    input  logic [31:0]         rt_data,
    input  logic                req,
    output logic                busy,
    output logic [31:0]         md_out,
    output logic [31:0]         hi,
    output logic [31:0]         lo
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    md_state_e        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg,   cnt_next;
    logic [31:0]      p_hi_reg,  p_hi_next;
    logic [31:0]      p_lo_reg,  p_lo_next;
    logic [31:0]      hi_reg,    hi_next;
    logic [31:0]      lo_reg,    lo_next;

    logic [31:0]      calc_hi;
    logic [31:0]      calc_lo;

    md_calc u_calc (
        .op     (mdu_op),
        .rs     (rs_data),
        .rt     (rt_data),
        .hi     (hi_reg),
        .lo     (lo_reg),
        .res_hi (calc_hi),
        .res_lo (calc_lo)
    );

    // State, counter, pending result and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            p_hi_reg  <= '0;
            p_lo_reg  <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            p_hi_reg  <= p_hi_next;
            p_lo_reg  <= p_lo_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    // Next-state logic: launch from IDLE unless an exception is being taken
    // in M; count down in RUN and commit the pending result on the last cycle.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        p_hi_next  = p_hi_reg;
        p_lo_next  = p_lo_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;

        case (state_reg)
            ST_IDLE: begin
                if (!req) begin
                    if (start && is_run_op(mdu_op)) begin
                        p_hi_next  = calc_hi;
                        p_lo_next  = calc_lo;
                        cnt_next   = is_div_op(mdu_op) ? DIV_LOAD : MULT_LOAD;
                        state_next = ST_RUN;
                    end else if (mdu_op == MDU_MTHI) begin
                        hi_next = rs_data;
                    end else if (mdu_op == MDU_MTLO) begin
                        lo_next = rs_data;
                    end
                end
            end
            ST_RUN: begin
                // <= guards against a zero count ever locking the unit busy.
                if (cnt_reg <= CNT_ONE) begin
                    hi_next    = p_hi_reg;
                    lo_next    = p_lo_reg;
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Zero-latency read port for mfhi/mflo and status outputs.
    always_comb begin
        md_out = 32'd0;
        if (mdu_op == MDU_MFHI) begin
            md_out = hi_reg;
        end else if (mdu_op == MDU_MFLO) begin
            md_out = lo_reg;
        end
    end

    assign busy = (state_reg == ST_RUN);
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases from the design notes plus
// randomized op/operand sequences against a behavioural HI/LO model.
// Honours MDU_MADD_EN the same way the design does.
module tb_md_unit;

    localparam int MULT_C = 5;
    localparam int DIV_C  = 10;

    localparam logic [4:0] OP_NONE  = 5'd0;
    localparam logic [4:0] OP_MULT  = 5'd1;
    localparam logic [4:0] OP_MULTU = 5'd2;
    localparam logic [4:0] OP_DIV   = 5'd3;
    localparam logic [4:0] OP_DIVU  = 5'd4;
    localparam logic [4:0] OP_MFHI  = 5'd5;
    localparam logic [4:0] OP_MFLO  = 5'd6;
    localparam logic [4:0] OP_MTHI  = 5'd7;
    localparam logic [4:0] OP_MTLO  = 5'd8;
    localparam logic [4:0] OP_MADD  = 5'd9;
    localparam logic [4:0] OP_MADDU = 5'd10;
    localparam logic [4:0] OP_MSUB  = 5'd11;
    localparam logic [4:0] OP_MSUBU = 5'd12;

`ifdef MDU_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  mdu_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        req;
    logic        busy;
    logic [31:0] md_out;
    logic [31:0] hi;
    logic [31:0] lo;

    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          n_checks = 0;
    int          n_fail   = 0;

    md_unit #(
        .MULT_CYCLES (MULT_C),
        .DIV_CYCLES  (DIV_C)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mdu_op  (mdu_op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .req     (req),
        .busy    (busy),
        .md_out  (md_out),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_multicycle(input logic [4:0] op);
        if (op >= OP_MULT && op <= OP_DIVU) return 1'b1;
        if (op >= OP_MADD && op <= OP_MSUBU) return MADD_EN;
        return 1'b0;
    endfunction

    // Architectural result of an op given operands and HI/LO at the start edge.
    function automatic logic [63:0] model_result(input logic [4:0] op,
                                                 input logic [31:0] a, input logic [31:0] b,
                                                 input logic [31:0] h, input logic [31:0] l);
        longint      sa, sb, sp;
        logic [63:0] up, acc;
        int          ia, ib;
        sa  = $signed(a);
        sb  = $signed(b);
        sp  = sa * sb;
        up  = {32'd0, a} * {32'd0, b};
        acc = {h, l};
        ia  = $signed(a);
        ib  = $signed(b);
        case (op)
            OP_MULT:  return sp;
            OP_MULTU: return up;
            OP_DIV: begin
                if (b == 32'd0) return acc;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(ia % ib), 32'(ia / ib)};
            end
            OP_DIVU: begin
                if (b == 32'd0) return acc;
                return {a % b, a / b};
            end
            OP_MADD:  return MADD_EN ? acc + 64'(sp) : acc;
            OP_MADDU: return MADD_EN ? acc + up : acc;
            OP_MSUB:  return MADD_EN ? acc - 64'(sp) : acc;
            OP_MSUBU: return MADD_EN ? acc - up : acc;
            default:  return acc;
        endcase
    endfunction

    // One start transaction; optionally with req at the start edge, a req
    // pulse mid-run, or a stray mthi while busy.
    task automatic run_md(input string tag, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input bit rq, input bit pulse, input bit junk);
        logic [63:0] r;
        bit          mc;
        bit          runs;
        int          n;
        mc   = is_multicycle(op);
        runs = mc && !rq;
        n    = (op == OP_DIV || op == OP_DIVU) ? DIV_C : MULT_C;
        r    = model_result(op, a, b, m_hi, m_lo);
        @(negedge clk);
        mdu_op = op; rs_data = a; rt_data = b; start = 1'b1; req = rq;
        @(negedge clk);
        start = 1'b0; mdu_op = OP_NONE; req = 1'b0;
        for (int i = 1; i <= n; i++) begin
            if (i > 1) @(negedge clk);
            if (junk && runs && i == 2) begin
                mdu_op = OP_MTHI; rs_data = 32'hDEAD_BEEF;
            end else begin
                mdu_op = OP_NONE;
            end
            if (pulse) req = (i == 4);
            check_eq({tag, "_busy"}, {31'd0, busy}, {31'd0, runs});
            if (i == 1) check_eq({tag, "_hi_early"}, hi, m_hi);
        end
        mdu_op = OP_NONE; req = 1'b0;
        @(negedge clk);
        if (runs) begin
            m_hi = r[63:32];
            m_lo = r[31:0];
        end
        check_eq({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_hi"}, hi, m_hi);
        check_eq({tag, "_lo"}, lo, m_lo);
        mdu_op = OP_MFHI; #1;
        check_eq({tag, "_mfhi"}, md_out, m_hi);
        mdu_op = OP_MFLO; #1;
        check_eq({tag, "_mflo"}, md_out, m_lo);
        mdu_op = OP_NONE; #1;
        check_eq({tag, "_mdout0"}, md_out, 32'd0);
        $display("txn %s op=%0d rs=%h rt=%h req=%0b -> hi=%h lo=%h", tag, op, a, b, rq, hi, lo);
    endtask

    // mthi/mtlo followed by mflo then mfhi on consecutive cycles.
    task automatic move_to(input string tag, input logic [4:0] op, input logic [31:0] v, input bit rq);
        @(negedge clk);
        mdu_op = op; rs_data = v; req = rq;
        @(negedge clk);
        req = 1'b0;
        if (!rq) begin
            if (op == OP_MTHI) m_hi = v;
            else m_lo = v;
        end
        mdu_op = OP_MFLO; #1;
        check_eq({tag, "_mflo"}, md_out, m_lo);
        @(negedge clk);
        mdu_op = OP_MFHI; #1;
        check_eq({tag, "_mfhi"}, md_out, m_hi);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
        mdu_op = OP_NONE;
        $display("txn %s op=%0d v=%h req=%0b -> hi=%h lo=%h", tag, op, v, rq, hi, lo);
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; mdu_op = OP_NONE;
        rs_data = '0; rt_data = '0; req = 1'b0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        mdu_op = OP_MFHI; #1;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_hi", hi, 32'd0);
        check_eq("rst_lo", lo, 32'd0);
        check_eq("rst_mfhi", md_out, 32'd0);
        mdu_op = OP_NONE;

        // Directed cases with literal expectations.
        run_md("mult_neg", OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 1'b0);
        check_eq("mult_neg_lit_hi", hi, 32'hFFFF_FFFF);
        check_eq("mult_neg_lit_lo", lo, 32'hFFFF_FFFA);
        run_md("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 1'b0);
        check_eq("multu_lit_hi", hi, 32'h0000_0002);
        check_eq("multu_lit_lo", lo, 32'hFFFF_FFFA);
        run_md("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0);
        check_eq("div_neg_lit_hi", hi, 32'hFFFF_FFFF);
        check_eq("div_neg_lit_lo", lo, 32'hFFFF_FFFD);
        run_md("divu_zero", OP_DIVU, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0);
        check_eq("divu_zero_lit_lo", lo, 32'hFFFF_FFFD);
        run_md("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        check_eq("div_ovf_lit_lo", lo, 32'h8000_0000);
        check_eq("div_ovf_lit_hi", hi, 32'd0);
        move_to("mthi", OP_MTHI, 32'h1234_5678, 1'b0);
        run_md("mult_req", OP_MULT, 32'd9, 32'd9, 1'b1, 1'b0, 1'b0);
        check_eq("mult_req_lit_hi", hi, 32'h1234_5678);
        move_to("mtlo_req", OP_MTLO, 32'h5555_AAAA, 1'b1);
        run_md("div_pulse", OP_DIV, 32'd100, 32'd7, 1'b0, 1'b1, 1'b1);
        check_eq("div_pulse_lit_lo", lo, 32'd14);
        check_eq("div_pulse_lit_hi", hi, 32'd2);

        // Reset at cycle 3 of a mult discards it.
        @(negedge clk);
        mdu_op = OP_MULT; rs_data = 32'd1000; rt_data = 32'd1000; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mdu_op = OP_NONE;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_mid_hi", hi, 32'd0);
        check_eq("rst_mid_lo", lo, 32'd0);
        repeat (MULT_C + 2) @(negedge clk);
        check_eq("rst_mid_lo_late", lo, 32'd0);
        $display("txn reset_mid_mult -> busy=%0b hi=%h lo=%h", busy, hi, lo);

        // maddu accumulation (or no-op when the feature is off).
        move_to("madd_sethi", OP_MTHI, 32'd0, 1'b0);
        move_to("madd_setlo", OP_MTLO, 32'hFFFF_FFFF, 1'b0);
        run_md("maddu", OP_MADDU, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        check_eq("maddu_lit_hi", hi, MADD_EN ? 32'd1 : 32'd0);
        check_eq("maddu_lit_lo", lo, MADD_EN ? 32'd0 : 32'hFFFF_FFFF);

        // Randomized sequence against the model.
        for (int k = 0; k < 30; k++) begin
            logic [4:0]  op;
            logic [31:0] a, b;
            bit          rq;
            op = 5'($urandom_range(1, 10));
            if (op == OP_MFHI || op == OP_MFLO) op = 5'($urandom_range(OP_MADD, OP_MSUBU));
            if (op == OP_MTHI || op == OP_MTLO) begin
                move_to($sformatf("rnd%0d", k), op, $urandom, ($urandom_range(0, 5) == 0));
            end else begin
                a  = rand_operand();
                b  = rand_operand();
                rq = ($urandom_range(0, 7) == 0);
                run_md($sformatf("rnd%0d", k), op, a, b, rq,
                       ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
